// File: rtl/rs_issue_scheduler_pkg.sv
// rtl/rs_issue_scheduler_pkg.sv - shared constants, entry type and wake-match helper for the RS scheduler (RS_AGE_SELECT_EN selects age-ordered pick)
package rs_issue_scheduler_pkg;

  localparam int RS_ENTRIES   = 8;
  localparam int NUM_PREGS    = 128;
  localparam int NUM_ROB_ENTS = 64;
  localparam int NUM_FUS      = 4;
  localparam int WAKE_PORTS   = NUM_FUS;
  localparam int PREG_W       = $clog2(NUM_PREGS);
  localparam int ROB_W        = $clog2(NUM_ROB_ENTS);
  localparam int RS_IDX_W     = $clog2(RS_ENTRIES);
  localparam int OCC_W        = RS_IDX_W + 1;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] dst_preg;
    logic [PREG_W-1:0] src1_preg;
    logic [PREG_W-1:0] src2_preg;
    logic              src1_rdy;
    logic              src2_rdy;
    logic [ROB_W-1:0]  rob_index;
  } rs_entry_t;

  // True when any valid broadcast port carries the given tag.
  function automatic logic wake_hit(input logic [PREG_W-1:0]            tag,
                                    input logic [WAKE_PORTS-1:0]        wv,
                                    input logic [WAKE_PORTS*PREG_W-1:0] wp);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < WAKE_PORTS; p++) begin
      if (wv[p] && (wp[p*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// rtl/rs_oldest_select.sv - age matrix plus oldest-eligible pick; plain priority encoder unless RS_AGE_SELECT_EN is defined
module rs_oldest_select
  import rs_issue_scheduler_pkg::*;
(
`ifdef RS_AGE_SELECT_EN
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_fire,
  input  logic [RS_IDX_W-1:0]   alloc_idx,
  input  logic [RS_ENTRIES-1:0] valid_vec,
`endif
  input  logic [RS_ENTRIES-1:0] eligible,
  output logic [RS_IDX_W-1:0]   grant_idx,
  output logic                  grant_any
);

  assign grant_any = |eligible;

`ifdef RS_AGE_SELECT_EN
  // older_q[j][i] = 1 means slot j was allocated before slot i
  logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older_q;
  logic [RS_ENTRIES-1:0]                 blocked;
  logic [RS_ENTRIES-1:0]                 winner;

  // New entry is younger than every live entry and older than nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      older_q <= '0;
    end else if (alloc_fire) begin
      for (int j = 0; j < RS_ENTRIES; j++) begin
        older_q[j][alloc_idx] <= valid_vec[j];
        older_q[alloc_idx][j] <= 1'b0;
      end
    end
  end

  // An eligible entry loses if any other eligible entry is older than it
  always_comb begin
    blocked   = '0;
    grant_idx = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int j = 0; j < RS_ENTRIES; j++) begin
        if (eligible[j] && older_q[j][i]) blocked[i] = 1'b1;
      end
    end
    winner = eligible & ~blocked;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (winner[i]) grant_idx = RS_IDX_W'(i);
    end
  end
`else
  // Lowest eligible slot index wins
  always_comb begin
    grant_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (eligible[i]) grant_idx = RS_IDX_W'(i);
    end
  end
`endif

endmodule

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - reservation-station wakeup/select for one execution pipe (RS_AGE_SELECT_EN enables oldest-first select)
module rs_issue_scheduler
  import rs_issue_scheduler_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [PREG_W-1:0]            alloc_dst_preg,
  input  logic [PREG_W-1:0]            alloc_src1_preg,
  input  logic [PREG_W-1:0]            alloc_src2_preg,
  input  logic                         alloc_src1_dp_en,
  input  logic                         alloc_src2_dp_en,
  input  logic                         alloc_src1_rdy,
  input  logic                         alloc_src2_rdy,
  input  logic [ROB_W-1:0]             alloc_rob_index,
  input  logic [WAKE_PORTS-1:0]        wake_valid,
  input  logic [WAKE_PORTS*PREG_W-1:0] wake_preg,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [RS_IDX_W-1:0]          issue_rs_index,
  output logic [PREG_W-1:0]            issue_dst_preg,
  output logic [PREG_W-1:0]            issue_src1_preg,
  output logic [PREG_W-1:0]            issue_src2_preg,
  output logic [ROB_W-1:0]             issue_rob_index,
  output logic [OCC_W-1:0]             occupancy
);

  rs_entry_t             entries [RS_ENTRIES];
  rs_entry_t             new_entry;
  logic [RS_ENTRIES-1:0] valid_vec;
  logic [RS_ENTRIES-1:0] eligible;
  logic [RS_IDX_W-1:0]   alloc_idx;
  logic [RS_IDX_W-1:0]   grant_idx;
  logic                  grant_any;
  logic [OCC_W-1:0]      occ_q;
  logic                  alloc_fire;
  logic                  issue_fire;

  assign alloc_ready = (occ_q < OCC_W'(RS_ENTRIES)) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_valid = grant_any && !flush;
  assign issue_fire  = issue_valid && issue_ready;
  assign occupancy   = occ_q;

  // Readiness is taken from registered bits only, so wakes show up a cycle later
  always_comb begin
    for (int i = 0; i < RS_ENTRIES; i++) begin
      valid_vec[i] = entries[i].valid;
      eligible[i]  = entries[i].valid && entries[i].src1_rdy && entries[i].src2_rdy;
    end
  end

  // Lowest free slot; a slot issuing this cycle is still valid and not reused
  always_comb begin
    alloc_idx = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) alloc_idx = RS_IDX_W'(i);
    end
  end

  // Incoming uOP, with same-cycle wake bypass folded into its ready bits
  always_comb begin
    new_entry           = '0;
    new_entry.valid     = 1'b1;
    new_entry.dst_preg  = alloc_dst_preg;
    new_entry.src1_preg = alloc_src1_preg;
    new_entry.src2_preg = alloc_src2_preg;
    new_entry.rob_index = alloc_rob_index;
    new_entry.src1_rdy  = !alloc_src1_dp_en || alloc_src1_rdy ||
                          wake_hit(alloc_src1_preg, wake_valid, wake_preg);
    new_entry.src2_rdy  = !alloc_src2_dp_en || alloc_src2_rdy ||
                          wake_hit(alloc_src2_preg, wake_valid, wake_preg);
  end

  rs_oldest_select u_select (
`ifdef RS_AGE_SELECT_EN
    .clk        (clk),
    .rst_n      (rst_n),
    .alloc_fire (alloc_fire),
    .alloc_idx  (alloc_idx),
    .valid_vec  (valid_vec),
`endif
    .eligible   (eligible),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  // Payload follows the selected slot; zero when nothing is eligible
  always_comb begin
    issue_rs_index  = '0;
    issue_dst_preg  = '0;
    issue_src1_preg = '0;
    issue_src2_preg = '0;
    issue_rob_index = '0;
    if (grant_any) begin
      issue_rs_index  = grant_idx;
      issue_dst_preg  = entries[grant_idx].dst_preg;
      issue_src1_preg = entries[grant_idx].src1_preg;
      issue_src2_preg = entries[grant_idx].src2_preg;
      issue_rob_index = entries[grant_idx].rob_index;
    end
  end

  // Entry state: wakeup, free on issue, write on alloc, squash on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_ENTRIES; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_ENTRIES; i++) entries[i].valid <= 1'b0;
    end else begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (entries[i].valid && !entries[i].src1_rdy &&
            wake_hit(entries[i].src1_preg, wake_valid, wake_preg))
          entries[i].src1_rdy <= 1'b1;
        if (entries[i].valid && !entries[i].src2_rdy &&
            wake_hit(entries[i].src2_preg, wake_valid, wake_preg))
          entries[i].src2_rdy <= 1'b1;
        if (issue_fire && (grant_idx == RS_IDX_W'(i)))
          entries[i].valid <= 1'b0;
        if (alloc_fire && (alloc_idx == RS_IDX_W'(i)))
          entries[i] <= new_entry;
      end
    end
  end

  // Valid-entry count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + OCC_W'(alloc_fire) - OCC_W'(issue_fire);
    end
  end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
Wakeup/select controller for one reservation station feeding one execution pipe (ALU_LOWER, ALU_UPPER, MUL or LSU).
- Accepts renamed uOPs from dispatch and tracks source-operand readiness from physical-register wakeup broadcasts.
- Each cycle, selects the oldest entry with all operands ready for issue to RegRead/EX.
- Frees the entry on the issue handshake; one instance per ex_pipe.

Parameters:
RS_ENTRIES, 8, number of scheduler entries
NUM_PREGS, 128, physical registers; PREG_W = $clog2(NUM_PREGS)
NUM_ROB_ENTS, 64, ROB size; ROB_W = $clog2(NUM_ROB_ENTS)
WAKE_PORTS, 4, wakeup broadcast ports (one per FU, = NUM_FUS)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  sync squash of all entries (branch mispredict/exception)
alloc_valid  in  1  dispatch offers a uOP
alloc_ready  out  1  scheduler can accept
alloc_dst_preg  in  PREG_W  destination preg
alloc_src1_preg  in  PREG_W  source 1 preg
alloc_src2_preg  in  PREG_W  source 2 preg
alloc_src1_dp_en  in  1  source 1 used (0 = ready/ignored)
alloc_src2_dp_en  in  1  source 2 used
alloc_src1_rdy  in  1  source 1 ready per rename ready-bit table
alloc_src2_rdy  in  1  source 2 ready per rename ready-bit table
alloc_rob_index  in  ROB_W  ROB slot
wake_valid  in  WAKE_PORTS  broadcast valid per port
wake_preg  in  WAKE_PORTS*PREG_W  broadcast preg tags, port p at [p*PREG_W +: PREG_W]
issue_valid  out  1  selected entry ready to issue
issue_ready  in  1  downstream accepts
issue_rs_index  out  $clog2(RS_ENTRIES)  slot issued (Ex_uOP.rs_entry_index)
issue_dst_preg  out  PREG_W  selected dst preg
issue_src1_preg  out  PREG_W  selected src1 preg
issue_src2_preg  out  PREG_W  selected src2 preg
issue_rob_index  out  ROB_W  selected ROB index
occupancy  out  $clog2(RS_ENTRIES)+1  valid entry count

Behaviour:
- Reset (rst_n low, async): all valid, ready and age bits cleared; occupancy=0, alloc_ready=1, issue_valid=0, issue_* payload outputs 0. Reset asserted mid-operation discards all entries immediately.
- alloc_ready = (occupancy < RS_ENTRIES) && !flush. No same-cycle reuse of a slot being issued; that slot is free next cycle.
- Alloc fires on alloc_valid && alloc_ready. The uOP is written to the lowest-index free slot.
  - srcN ready bit = !dp_en || alloc_srcN_rdy || match against any same-cycle valid wake port. Same-cycle wake bypass is mandatory; no lost wakeups.
- Wakeup: each cycle, every valid entry compares each unready source against all wake ports and sets the ready bit on a match. Multiple ports matching the same tag are harmless.
- Entry eligible = valid && src1_rdy && src2_rdy, computed from registered bits only.
  - Earliest issue is the cycle after alloc.
  - Earliest issue is the cycle after the wake cycle.
- Select: oldest eligible entry by age matrix. older[j][i]=1 means j was allocated before i. On alloc into k: older[j][k]=1 for every currently valid j, and older[k][*]=0.
- issue_valid = any eligible && !flush. issue_* reflect the selected entry combinationally and stay stable while issue_valid && !issue_ready, unless an older entry becomes eligible.
- Issue fires on issue_valid && issue_ready; the slot is invalidated at the edge.
- occupancy next = occupancy + alloc_fire - issue_fire. Alloc and issue may both fire in one cycle.
- flush: at the next edge all valid bits clear and occupancy goes to 0. Alloc and issue are both blocked in the flush cycle.
- Wakeups arriving for freed or empty slots are ignored.

Optional Feature:
RS_AGE_SELECT_EN
- Defined: oldest-first select via the age matrix, as described above.
- Undefined: age matrix is not built; select is fixed priority, lowest eligible slot index wins. All other behaviour is identical.

Decomposition:
- CORE_PKG gains:
  - constants RS_ENTRIES, NUM_PREGS, NUM_ROB_ENTS, NUM_FUS
  - typedef Rs_Entry (valid, dst_preg, src1_preg, src2_preg, src1_rdy, src2_rdy, rob_index)
- Sub-module rs_oldest_select: age-matrix storage plus eligible-vector to one-hot/index pick. When RS_AGE_SELECT_EN is undefined it reduces to a priority encoder.

Test Plan:
- Alloc dst=10, src1=20 rdy, src2 dp_en=0, rob=5 -> next cycle issue_valid=1, issue_rs_index=0, issue_rob_index=5. Issue accepted -> occupancy 1->0.
- Alloc src1=33 unready, then wake_preg[port2]=33 in cycle 3 -> issue_valid rises in cycle 4, not earlier.
- Alloc with src1=40 unready while wake port0=40 in the same cycle -> entry issues next cycle (bypass).
- Fill 8 entries, all unready, issue_ready=1 -> alloc_ready=0, occupancy=8. Wake one source -> issue, alloc_ready=1 the following cycle.
- Alloc A into slot 3, then B into slot 0, wake both in the same cycle -> A issues first (RS_AGE_SELECT_EN); B issues first without the macro.
- 5 valid entries, flush=1 with issue_ready=1 -> issue_valid=0 in the flush cycle, occupancy=0 next cycle. Also assert rst_n low mid-stream -> outputs clear immediately.
